fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the async FIFO write port between NREQ
//  requesters in the write clock domain. Each requester presents one word per
//  valid/accept handshake. The arbiter drives winc/wdata into the FIFO and
//  back-pressures all requesters while wfull is high. It also keeps write and
//  stall statistics for debug.
// PARAMETERS
//  DSIZE  32  data word width; equals the FIFO DSIZE
//  NREQ   4   number of requesters, 2..16
//  IDXW   2   requester index width, = clog2(NREQ)
//  CNTW   16  width of the statistics counters
// PORTS
//  wclk        in   1           write-domain clock, rising edge
//  wrst        in   1           asynchronous reset, active-high
//  req         in   NREQ        per-requester valid
//  req_data    in   NREQ*DSIZE  requester i's word in bits [i*DSIZE +: DSIZE]
//  req_last    in   NREQ        last word of a burst; used only with FIFO_ARB_LOCK_EN
//  gnt         out  NREQ        one-hot accept: word i is written at this edge
//  gnt_idx     out  IDXW        index of the selected requester (valid when winc=1)
//  winc        out  1           FIFO write increment, = |gnt
//  wdata       out  DSIZE       FIFO write data, = selected req_data slice
//  wfull       in   1           FIFO full flag
//  wr_count    out  CNTW        total accepted words; wraps
//  stall_count out  CNTW        cycles with |req && wfull; saturates at all-ones
// BEHAVIOUR
//  - gnt, gnt_idx, winc and wdata are combinational from the registered state
//    and the current req/wfull. The write lands at the same edge as the accept,
//    so wfull is always exact and there is no overflow slack.
//  - Handshake: req[i] is held, and req_data slice i is held stable, until an
//    edge at which gnt[i]=1. A requester must not drop req[i] without a grant.
//    Violating this gives undefined data but never a spurious winc.
//  - Arbitration: search starts at last_idx+1 mod NREQ and picks the first i
//    with req[i]=1.
//  - gnt[sel]=1 only if wfull=0 and wrst=0. Otherwise gnt=0 and winc=0.
//  - gnt_idx = sel whenever any req is high, else 0.
//  - last_idx <= sel on each accept; it holds when there is no accept.
//  - Reset values: last_idx=NREQ-1 (requester 0 has first priority),
//    state=ARB, wr_count=0, stall_count=0. All outputs are 0 while wrst=1.
//  - wr_count increments by 1 per accept and wraps from 2^CNTW-1 to 0.
//  - stall_count increments when |req && wfull and stops at 2^CNTW-1.
//  - Boundary cases:
//    - wfull rising blocks the accept in that same cycle.
//    - wfull low with one requester: one word per cycle, back-to-back.
//    - Reset asserted mid-burst aborts the lock immediately (asynchronous).
//      The pointer returns to NREQ-1 and the word pending at reset is not written.
//    - NREQ not a power of two: the wrap is explicit mod NREQ, and index
//      values >= NREQ are never produced.
// CONFIGURATION
//  FIFO_ARB_LOCK_EN defined: burst lock with a 2-state FSM (ARB, LOCK) and an
//  owner register (IDXW bits, reset 0).
//   ARB  -> LOCK on an accept from i with req_last[i]=0; owner <= i.
//   LOCK: only gnt[owner] is possible; other requesters wait.
//   LOCK -> ARB on an accept from owner with req_last[owner]=1.
//   LOCK with req[owner]=0 or wfull=1: stay in LOCK and grant nothing.
//   On leaving LOCK, last_idx=owner, so the next search starts at owner+1.
//  FIFO_ARB_LOCK_EN undefined: req_last is ignored, the FSM and owner register
//  are removed, and every accepted word re-arbitrates.
// TESTING
//  1 Reset; req=4'b1111, wfull=0 for 8 cycles -> gnt sequence is
//    0001,0010,0100,1000,0001,...; winc=1 every cycle; wr_count=8.
//  2 req=4'b0101 with wfull=1 for 5 cycles -> gnt=0, winc=0, stall_count=5.
//    Then wfull=0 -> gnt=0001, then 0100.
//  3 Only req[2] held 10 cycles, wdata=i*0x11 -> 10 consecutive winc with
//    wdata 0x00..0x99; gnt_idx=2 throughout.
//  4 Assert wrst mid-stream with req=4'b1010 -> winc=0 immediately.
//    After release, the first gnt is 0010 (requester 1 wins from pointer NREQ-1).
//  5 FIFO_ARB_LOCK_EN: req0 sends a 3-beat burst (req_last on beat 3) while
//    req1 is held -> gnt 0001 x3, then 0010.
//    Same run with the macro undefined -> 0001,0010,0001,...
//  6 Force wr_count=2^CNTW-2 and stall_count near max, then 3 accepts and
//    3 stall cycles -> wr_count wraps to 1; stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Define FIFO_ARB_LOCK_EN to hold the grant on one requester until its req_last beat.
module fifo_wr_arbiter #(
   parameter int DSIZE = 32,
   parameter int NREQ  = 4,
   parameter int IDXW  = 2,
   parameter int CNTW  = 16
) (
   input  logic                  wclk_i,
   input  logic                  wrst_i,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*DSIZE-1:0] req_data_i,
   input  logic [NREQ-1:0]       req_last_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic [IDXW-1:0]       gnt_idx_o,
   output logic                  winc_o,
   output logic [DSIZE-1:0]      wdata_o,
   input  logic                  wfull_i,
   output logic [CNTW-1:0]       wr_count_o,
   output logic [CNTW-1:0]       stall_count_o
);
   localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

   logic [IDXW-1:0] last_q, last_d, rr_sel, sel;
   logic            rr_vld, sel_vld, accept, any_req;
   logic [CNTW-1:0] wr_cnt_q, wr_cnt_d, stall_cnt_q, stall_cnt_d;

   // Scan farthest-to-nearest so the first requester after last_q wins; wrap is explicit mod NREQ.
   always_comb begin
      int c;
      rr_sel = '0;
      rr_vld = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         c = int'(last_q) + k;
         if (c >= NREQ) c = c - NREQ;
         if (req_i[c]) begin
            rr_sel = IDXW'(c);
            rr_vld = 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_LOCK_EN
   typedef enum logic {ARB, LOCK} state_e;
   state_e          state_q, state_d;
   logic [IDXW-1:0] owner_q, owner_d;

   always_comb begin
      sel     = rr_sel;
      sel_vld = rr_vld;
      if (state_q == LOCK) begin
         sel     = owner_q;
         sel_vld = req_i[owner_q];
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ARB:  if (accept && !req_last_i[sel]) begin
                  state_d = LOCK;
                  owner_d = sel;
               end
         LOCK: if (accept && req_last_i[owner_q]) state_d = ARB;
      endcase
   end

   always_ff @(posedge wclk_i or posedge wrst_i) begin
      if (wrst_i) begin
         state_q <= ARB;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end
`else
   logic unused_last;
   assign unused_last = ^req_last_i;
   assign sel     = rr_sel;
   assign sel_vld = rr_vld;
`endif

   // The write lands on the accept edge, so wfull gates the grant in the same cycle.
   assign any_req = |req_i;
   assign accept  = sel_vld & ~wfull_i & ~wrst_i;
   assign winc_o  = accept;

   always_comb begin
      gnt_o = '0;
      if (accept) gnt_o[sel] = 1'b1;
   end

   assign gnt_idx_o = (any_req && !wrst_i) ? sel : '0;
   assign wdata_o   = (any_req && !wrst_i) ? req_data_i[sel*DSIZE +: DSIZE] : '0;

   assign last_d      = accept ? sel : last_q;
   assign wr_cnt_d    = accept ? wr_cnt_q + CNTW'(1) : wr_cnt_q;
   assign stall_cnt_d = (any_req && wfull_i && stall_cnt_q != '1) ? stall_cnt_q + CNTW'(1)
                                                                  : stall_cnt_q;

   always_ff @(posedge wclk_i or posedge wrst_i) begin
      if (wrst_i) begin
         last_q      <= LAST_RST;
         wr_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         last_q      <= last_d;
         wr_cnt_q    <= wr_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign wr_count_o    = wr_cnt_q;
   assign stall_count_o = stall_cnt_q;
endmodule
